// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_unit_pkg
// Purpose : Shared types and codes for the registered PC-source unit:
//           FSM states, branch-condition codes, next-PC source codes and
//           exception cause codes.
// Revision: 1.0  initial release
// ============================================================================
package pc_unit_pkg;

  // Exception sequencing states
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_TRAP    = 2'd1,
    ST_HANDLER = 2'd2
  } pc_state_e;

  // Branch condition codes (cond_mode)
  localparam logic [1:0] COND_EQ = 2'b00;  // alu_zero
  localparam logic [1:0] COND_NE = 2'b01;  // !alu_zero
  localparam logic [1:0] COND_GT = 2'b10;  // alu_gt
  localparam logic [1:0] COND_LE = 2'b11;  // !alu_gt

  // Next-PC source codes (src_sel)
  localparam logic [1:0] SRC_ALU_RESULT = 2'b00;
  localparam logic [1:0] SRC_ALU_OUT    = 2'b01;
  localparam logic [1:0] SRC_JUMP       = 2'b10;
  localparam logic [1:0] SRC_EPC        = 2'b11;

  // Exception cause codes (exc_cause)
  localparam logic [1:0] CAUSE_OPCODE   = 2'd0;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'd1;
  localparam logic [1:0] CAUSE_DIV_ZERO = 2'd2;
  localparam logic [1:0] CAUSE_RESERVED = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pc_source_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_source_unit_if
// Purpose : Control/ALU-facing bundle of the PC-source unit. The master side
//           (control FSM + ALU) drives the request/data signals; the slave
//           side (pc_source_unit) drives PC, EPC and exception status.
// Revision: 1.0  initial release
// ============================================================================
interface pc_source_unit_if #(
  parameter int WIDTH = 32
);
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       cond_mode;
  logic             alu_zero;
  logic             alu_gt;
  logic [1:0]       src_sel;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] alu_out;
  logic [25:0]      instr_index;
  logic             exc_req;
  logic [1:0]       exc_cause;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] epc;
  logic             exc_ack;
  logic [1:0]       cause_q;
  logic             in_handler;
  logic             double_fault;

  modport master (
    output pc_write, pc_write_cond, cond_mode, alu_zero, alu_gt, src_sel,
           alu_result, alu_out, instr_index, exc_req, exc_cause,
    input  pc, epc, exc_ack, cause_q, in_handler, double_fault
  );

  modport slave (
    input  pc_write, pc_write_cond, cond_mode, alu_zero, alu_gt, src_sel,
           alu_result, alu_out, instr_index, exc_req, exc_cause,
    output pc, epc, exc_ack, cause_q, in_handler, double_fault
  );

endinterface
`default_nettype wire

// File: rtl/pc_source_unit_pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module  : pc_next_mux
// Purpose : 4:1 next-PC selector indexed by the src_sel code.
// Revision: 1.0  initial release
// ============================================================================
module pc_next_mux
  import pc_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic [1:0]       sel,
  input  wire logic [WIDTH-1:0] in_alu_result,
  input  wire logic [WIDTH-1:0] in_alu_out,
  input  wire logic [WIDTH-1:0] in_jump,
  input  wire logic [WIDTH-1:0] in_epc,
  output logic      [WIDTH-1:0] next_pc
);

  // Pure selection; no priority between sources
  always_comb begin
    next_pc = in_alu_result;
    case (sel)
      SRC_ALU_RESULT: next_pc = in_alu_result;
      SRC_ALU_OUT:    next_pc = in_alu_out;
      SRC_JUMP:       next_pc = in_jump;
      SRC_EPC:        next_pc = in_epc;
      default:        next_pc = in_alu_result;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_source_unit.sv
`default_nettype none
// ============================================================================
// Module  : pc_source_unit
// Purpose : Registered PC/EPC unit for the multicycle MIPS datapath. Selects
//           the next PC, qualifies conditional branches and sequences
//           exception entry (RUN->TRAP->HANDLER) and eret, with a sticky
//           double-fault guard for exceptions raised inside the handler.
// Revision: 1.0  initial release
// ============================================================================
module pc_source_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_BASE     = WIDTH'('h0000_0100),
  parameter int               VEC_STRIDE   = 4,
  parameter logic [WIDTH-1:0] DF_VECTOR    = WIDTH'('h0000_0180),
  parameter int               EPC_OFFSET   = 4
) (
  input wire logic         clk,
  input wire logic         reset_n,
  pc_source_unit_if.slave  bus
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [1:0]       cause_lat_q, cause_lat_d;
  logic             exc_ack_q, exc_ack_d;
  logic             in_handler_q, in_handler_d;
  logic             double_fault_q, double_fault_d;

  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] mux_pc;
  logic [WIDTH-1:0] exc_vector;
  logic             cond_true;
  logic             take;

  // Jump target keeps the PC region bits above bit 27; at WIDTH==28 there are none
  generate
    if (WIDTH > 28) begin : g_jump_region
      assign jump_target = {pc_q[WIDTH-1:28], bus.instr_index, 2'b00};
    end else begin : g_jump_flat
      assign jump_target = {bus.instr_index, 2'b00};
    end
  endgenerate

  assign exc_vector = EXC_BASE + (WIDTH'(bus.exc_cause) * WIDTH'(VEC_STRIDE));

  pc_next_mux #(
    .WIDTH (WIDTH)
  ) u_next_mux (
    .sel           (bus.src_sel),
    .in_alu_result (bus.alu_result),
    .in_alu_out    (bus.alu_out),
    .in_jump       (jump_target),
    .in_epc        (epc_q),
    .next_pc       (mux_pc)
  );

  // Branch qualification from ALU flags
  always_comb begin
    cond_true = 1'b0;
    case (bus.cond_mode)
      COND_EQ: cond_true = bus.alu_zero;
      COND_NE: cond_true = !bus.alu_zero;
      COND_GT: cond_true = bus.alu_gt;
      COND_LE: cond_true = !bus.alu_gt;
      default: cond_true = 1'b0;
    endcase
    take = bus.pc_write | (bus.pc_write_cond & cond_true);
  end

  // Next-state for PC, EPC, cause and exception sequencing
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    epc_d          = epc_q;
    cause_lat_d    = cause_lat_q;
    exc_ack_d      = 1'b0;
    double_fault_d = double_fault_q;
    case (state_q)
      ST_RUN: begin
        if (bus.exc_req) begin
          // Exception wins over any simultaneous PC write; PC was already incremented
          epc_d       = pc_q - WIDTH'(EPC_OFFSET);
          cause_lat_d = bus.exc_cause;
          pc_d        = exc_vector;
          exc_ack_d   = 1'b1;
          state_d     = ST_TRAP;
        end else if (take) begin
          // eret from RUN just reloads EPC; no state change
          pc_d = mux_pc;
        end
      end
      ST_TRAP: begin
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (bus.exc_req) begin
          pc_d           = DF_VECTOR;
          double_fault_d = 1'b1;
        end else if (take) begin
          pc_d = mux_pc;
          if (bus.src_sel == SRC_EPC) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    in_handler_d = (state_d != ST_RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_VECTOR;
      epc_q          <= '0;
      cause_lat_q    <= CAUSE_OPCODE;
      exc_ack_q      <= 1'b0;
      in_handler_q   <= 1'b0;
      double_fault_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      epc_q          <= epc_d;
      cause_lat_q    <= cause_lat_d;
      exc_ack_q      <= exc_ack_d;
      in_handler_q   <= in_handler_d;
      double_fault_q <= double_fault_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.epc          = epc_q;
  assign bus.cause_q      = cause_lat_q;
  assign bus.exc_ack      = exc_ack_q;
  assign bus.in_handler   = in_handler_q;
  assign bus.double_fault = double_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_source_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_source_unit
// Purpose : Self-checking bench for pc_source_unit: directed scenarios plus
//           randomized cycles against a behavioural reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_pc_source_unit;

  logic clk;
  logic reset_n;

  pc_source_unit_if #(.WIDTH(32)) bus_if ();

  pc_source_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0),
    .EXC_BASE     (32'h0000_0100),
    .VEC_STRIDE   (4),
    .DF_VECTOR    (32'h0000_0180),
    .EPC_OFFSET   (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  logic        m_ack, m_inh, m_df;
  int          m_mode;   // 0 running, 1 trap cycle, 2 inside handler

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'd0;
    m_ack = 1'b0; m_inh = 1'b0; m_df = 1'b0; m_mode = 0;
  endtask

  // One clock edge of the architectural behaviour, from the current inputs
  task automatic model_step();
    logic        cond, tk;
    logic [31:0] src;
    case (bus_if.cond_mode)
      2'b00:   cond = bus_if.alu_zero;
      2'b01:   cond = !bus_if.alu_zero;
      2'b10:   cond = bus_if.alu_gt;
      default: cond = !bus_if.alu_gt;
    endcase
    tk = bus_if.pc_write || (bus_if.pc_write_cond && cond);
    case (bus_if.src_sel)
      2'b00:   src = bus_if.alu_result;
      2'b01:   src = bus_if.alu_out;
      2'b10:   src = (m_pc & 32'hF000_0000) | (32'(bus_if.instr_index) << 2);
      default: src = m_epc;
    endcase
    m_ack = 1'b0;
    if (m_mode == 0) begin
      if (bus_if.exc_req) begin
        m_epc   = m_pc - 32'd4;
        m_cause = bus_if.exc_cause;
        m_pc    = 32'h100 + 32'(bus_if.exc_cause) * 32'd4;
        m_ack   = 1'b1;
        m_mode  = 1;
      end else if (tk) begin
        m_pc = src;
      end
    end else if (m_mode == 1) begin
      m_mode = 2;
    end else begin
      if (bus_if.exc_req) begin
        m_pc = 32'h180;
        m_df = 1'b1;
      end else if (tk) begin
        m_pc = src;
        if (bus_if.src_sel == 2'b11) m_mode = 0;
      end
    end
    m_inh = (m_mode != 0);
  endtask

  task automatic check_all(input string where);
    chk({where, ".pc"},           64'(bus_if.pc),           64'(m_pc));
    chk({where, ".epc"},          64'(bus_if.epc),          64'(m_epc));
    chk({where, ".cause_q"},      64'(bus_if.cause_q),      64'(m_cause));
    chk({where, ".exc_ack"},      64'(bus_if.exc_ack),      64'(m_ack));
    chk({where, ".in_handler"},   64'(bus_if.in_handler),   64'(m_inh));
    chk({where, ".double_fault"}, 64'(bus_if.double_fault), 64'(m_df));
  endtask

  task automatic idle_inputs();
    bus_if.pc_write = 1'b0; bus_if.pc_write_cond = 1'b0; bus_if.cond_mode = 2'b00;
    bus_if.alu_zero = 1'b0; bus_if.alu_gt = 1'b0; bus_if.src_sel = 2'b00;
    bus_if.alu_result = 32'h0; bus_if.alu_out = 32'h0; bus_if.instr_index = 26'h0;
    bus_if.exc_req = 1'b0; bus_if.exc_cause = 2'd0;
  endtask

  // Inputs are set while clk is low; model advances, edge occurs, outputs checked #1 later
  task automatic step(input string where);
    model_step();
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  initial begin
    idle_inputs();
    model_reset();

    // Reset with pc_write held high
    reset_n = 1'b0;
    bus_if.pc_write = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_pc", 64'(bus_if.pc), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_if.src_sel = 2'b00; bus_if.alu_result = 32'd4;
    step("first_write");
    chk("first_pc", 64'(bus_if.pc), 64'h4);

    // Conditional NE branch: not taken, then taken
    @(negedge clk);
    bus_if.pc_write = 1'b0; bus_if.pc_write_cond = 1'b1; bus_if.cond_mode = 2'b01;
    bus_if.alu_zero = 1'b1; bus_if.src_sel = 2'b01; bus_if.alu_out = 32'h40;
    step("ne_not_taken");
    chk("ne_hold_pc", 64'(bus_if.pc), 64'h4);
    @(negedge clk);
    bus_if.alu_zero = 1'b0;
    step("ne_taken");
    chk("ne_pc", 64'(bus_if.pc), 64'h40);

    // Exception entry overrides simultaneous pc_write
    @(negedge clk);
    idle_inputs();
    bus_if.pc_write = 1'b1; bus_if.alu_result = 32'h24;
    step("set_pc24");
    @(negedge clk);
    bus_if.exc_req = 1'b1; bus_if.exc_cause = 2'd1; bus_if.alu_result = 32'h999;
    step("exc_entry");
    chk("exc_epc", 64'(bus_if.epc), 64'h20);
    chk("exc_pc", 64'(bus_if.pc), 64'h104);
    chk("exc_ack_hi", 64'(bus_if.exc_ack), 64'h1);
    @(negedge clk);
    idle_inputs();
    step("trap_to_handler");
    chk("exc_ack_lo", 64'(bus_if.exc_ack), 64'h0);
    chk("handler_flag", 64'(bus_if.in_handler), 64'h1);

    // Double fault, then eret
    @(negedge clk);
    bus_if.exc_req = 1'b1; bus_if.exc_cause = 2'd2;
    step("double_fault");
    chk("df_pc", 64'(bus_if.pc), 64'h180);
    chk("df_epc", 64'(bus_if.epc), 64'h20);
    @(negedge clk);
    idle_inputs();
    bus_if.pc_write = 1'b1; bus_if.src_sel = 2'b11;
    step("eret");
    chk("eret_pc", 64'(bus_if.pc), 64'h20);
    chk("eret_df_sticky", 64'(bus_if.double_fault), 64'h1);
    chk("eret_run", 64'(bus_if.in_handler), 64'h0);

    // Jump target keeps upper region bits
    @(negedge clk);
    bus_if.src_sel = 2'b00; bus_if.alu_result = 32'h8000_0010;
    step("set_pc_hi");
    @(negedge clk);
    bus_if.src_sel = 2'b10; bus_if.instr_index = 26'h123;
    step("jump");
    chk("jump_pc", 64'(bus_if.pc), 64'h8000_048C);

    // EPC wraps below zero; cause 3 vectors normally
    @(negedge clk);
    bus_if.src_sel = 2'b00; bus_if.alu_result = 32'h0;
    step("set_pc0");
    @(negedge clk);
    idle_inputs();
    bus_if.exc_req = 1'b1; bus_if.exc_cause = 2'd3;
    step("exc_wrap");
    chk("wrap_epc", 64'(bus_if.epc), 64'hFFFF_FFFC);
    chk("cause3_pc", 64'(bus_if.pc), 64'h10C);

    // Asynchronous reset while in TRAP
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_pc", 64'(bus_if.pc), 64'h0);
    chk("async_ack", 64'(bus_if.exc_ack), 64'h0);
    chk("async_inh", 64'(bus_if.in_handler), 64'h0);
    chk("async_df", 64'(bus_if.double_fault), 64'h0);
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    step("post_reset");

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus_if.pc_write      = ($urandom_range(0, 3) == 0);
      bus_if.pc_write_cond = ($urandom_range(0, 2) == 0);
      bus_if.cond_mode     = 2'($urandom_range(0, 3));
      bus_if.alu_zero      = 1'($urandom_range(0, 1));
      bus_if.alu_gt        = 1'($urandom_range(0, 1));
      bus_if.src_sel       = 2'($urandom_range(0, 3));
      bus_if.alu_result    = $urandom;
      bus_if.alu_out       = $urandom;
      bus_if.instr_index   = 26'($urandom);
      bus_if.exc_req       = ($urandom_range(0, 9) == 0);
      bus_if.exc_cause     = 2'($urandom_range(0, 3));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
